// File: rtl/uart_dbg_pkg.sv
// Shared types and constants for the UART debug bridge.
package uart_dbg_pkg;

  // Parser FSM states for the host command frame.
  typedef enum logic [2:0] {
    P_CMD    = 3'd0,
    P_ADDR   = 3'd1,
    P_DATA   = 3'd2,
    ISSUE    = 3'd3,
    WAIT_RDY = 3'd4,
    REPLY    = 3'd5
  } parser_state_e;

  localparam int         FRAME_BYTES = 9;
  localparam int         REPLY_BYTES = 4;
  localparam logic [7:0] DBG_CMD_NOP = 8'h00;

  // Select one byte of a 32-bit word, byte 0 being the least significant.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_dbg_bridge_phy.sv
// 8N1 UART physical layer: RX synchroniser/deserialiser and TX serialiser.
module uart_phy #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       rx_ferr,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy
);

  localparam int               HALF      = CLKS_PER_BIT / 2;
  localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic             rx_meta_r, rx_sync_r, rx_prev_r;
  logic [1:0]       rx_state_r;
  logic [CNT_W-1:0] rx_cnt_r;
  logic [2:0]       rx_bit_r;
  logic [7:0]       rx_shift_r;
  logic             rx_done_r, rx_ferr_r;

  logic             tx_r;
  logic [8:0]       tx_shift_r;
  logic [3:0]       tx_bits_r;
  logic [CNT_W-1:0] tx_cnt_r;
  logic             tx_ready_s;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receive FSM: start-bit qualification at half bit, mid-bit sampling, stop check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= '0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_done_r  <= 1'b0;
      rx_ferr_r  <= 1'b0;
    end else begin
      rx_done_r <= 1'b0;
      rx_ferr_r <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          rx_cnt_r <= '0;
          // Edge rather than level, so a line held low after a framing error is not a new start.
          if (rx_prev_r && !rx_sync_r) rx_state_r <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_r == HALF_LAST) begin
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= '0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
            else                  rx_bit_r   <= rx_bit_r + 3'd1;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= '0;
            rx_state_r <= RX_IDLE;
            if (rx_sync_r) rx_done_r <= 1'b1;
            else           rx_ferr_r <= 1'b1;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Ready when idle, or in the final cycle of a stop bit so bytes chain without gaps.
  assign tx_ready_s = (tx_bits_r == 4'd0) || ((tx_bits_r == 4'd1) && (tx_cnt_r == BIT_LAST));

  // Transmit shifter: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r       <= 1'b1;
      tx_shift_r <= 9'h1FF;
      tx_bits_r  <= 4'd0;
      tx_cnt_r   <= '0;
    end else if (tx_valid && tx_ready_s) begin
      tx_r       <= 1'b0;
      tx_shift_r <= {1'b1, tx_byte};
      tx_bits_r  <= 4'd10;
      tx_cnt_r   <= '0;
    end else if (tx_bits_r != 4'd0) begin
      if (tx_cnt_r == BIT_LAST) begin
        tx_cnt_r   <= '0;
        tx_bits_r  <= tx_bits_r - 4'd1;
        tx_r       <= tx_shift_r[0];
        tx_shift_r <= {1'b1, tx_shift_r[8:1]};
      end else begin
        tx_cnt_r <= tx_cnt_r + CNT_ONE;
      end
    end else begin
      tx_r <= 1'b1;
    end
  end

  assign tx       = tx_r;
  assign rx_byte  = rx_shift_r;
  assign rx_done  = rx_done_r;
  assign rx_ferr  = rx_ferr_r;
  assign tx_ready = tx_ready_s;
  assign tx_busy  = (tx_bits_r != 4'd0);

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART-to-debug-port bridge: parses 9-byte command frames, issues them, replies with read data.
module uart_dbg_bridge
  import uart_dbg_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i
);

  localparam int            CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int            TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int            TO_W         = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_ONE     = TO_W'(1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TO_LIMIT - 1);
  localparam int            FIELD_BYTES  = (FRAME_BYTES - 1) / 2;
  localparam logic [1:0]    FIELD_LAST   = 2'(FIELD_BYTES - 1);
  localparam logic [2:0]    REPLY_END    = 3'(REPLY_BYTES);

  parser_state_e   state_r;
  logic [1:0]      byte_idx_r;
  logic [TO_W-1:0] to_cnt_r;
  logic [7:0]      cmd_buf_r;
  logic [31:0]     addr_buf_r, data_buf_r, rdata_r;
  logic [2:0]      reply_idx_r;
  logic [7:0]      dbg_cmd_r;
  logic [31:0]     dbg_addr_r, dbg_data_r;

  logic [7:0]      rx_byte_s, tx_byte_s;
  logic            rx_done_s, rx_ferr_s, tx_ready_s, tx_busy_s, tx_valid_s;

  uart_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .clk      (clk),
    .rst_n    (rstn_i),
    .rx       (rx_i),
    .tx       (tx_o),
    .rx_byte  (rx_byte_s),
    .rx_done  (rx_done_s),
    .rx_ferr  (rx_ferr_s),
    .tx_byte  (tx_byte_s),
    .tx_valid (tx_valid_s),
    .tx_ready (tx_ready_s),
    .tx_busy  (tx_busy_s)
  );

  // Offer the next reply byte to the transmitter while bytes remain.
  always_comb begin
    tx_valid_s = 1'b0;
    tx_byte_s  = word_byte(rdata_r, reply_idx_r[1:0]);
    if ((state_r == REPLY) && (reply_idx_r < REPLY_END)) tx_valid_s = 1'b1;
    else                                                 tx_valid_s = 1'b0;
  end

  // Frame parser, command issue, ready handshake and reply sequencing.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r     <= P_CMD;
      byte_idx_r  <= 2'd0;
      to_cnt_r    <= '0;
      cmd_buf_r   <= 8'h00;
      addr_buf_r  <= 32'h0;
      data_buf_r  <= 32'h0;
      rdata_r     <= 32'h0;
      reply_idx_r <= 3'd0;
      dbg_cmd_r   <= DBG_CMD_NOP;
      dbg_addr_r  <= 32'h0;
      dbg_data_r  <= 32'h0;
    end else begin
      case (state_r)
        P_CMD: begin
          to_cnt_r   <= '0;
          byte_idx_r <= 2'd0;
          if (rx_done_s && (rx_byte_s != DBG_CMD_NOP)) begin
            cmd_buf_r <= rx_byte_s;
            state_r   <= P_ADDR;
          end
        end
        P_ADDR, P_DATA: begin
          if (rx_ferr_s) begin
            state_r <= P_CMD;
          end else if (rx_done_s) begin
            to_cnt_r <= '0;
            if (state_r == P_ADDR) addr_buf_r <= {rx_byte_s, addr_buf_r[31:8]};
            else                   data_buf_r <= {rx_byte_s, data_buf_r[31:8]};
            if (byte_idx_r == FIELD_LAST) begin
              byte_idx_r <= 2'd0;
              state_r    <= (state_r == P_ADDR) ? P_DATA : ISSUE;
            end else begin
              byte_idx_r <= byte_idx_r + 2'd1;
            end
          end else if (to_cnt_r == TO_LAST) begin
            state_r <= P_CMD;
          end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
          end
        end
        ISSUE: begin
          dbg_cmd_r  <= cmd_buf_r;
          dbg_addr_r <= addr_buf_r;
          dbg_data_r <= data_buf_r;
          state_r    <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (dbg_ready_i) begin
            rdata_r     <= dbg_data_i;
            dbg_cmd_r   <= DBG_CMD_NOP;
            reply_idx_r <= 3'd0;
            state_r     <= REPLY;
          end
        end
        REPLY: begin
          // Stay here until the last byte has left the line, so echoes are not parsed.
          if (tx_valid_s && tx_ready_s)                   reply_idx_r <= reply_idx_r + 3'd1;
          else if ((reply_idx_r == REPLY_END) && !tx_busy_s) state_r  <= P_CMD;
        end
        default: state_r <= P_CMD;
      endcase
    end
  end

  assign dbg_cmd_o  = dbg_cmd_r;
  assign dbg_addr_o = dbg_addr_r;
  assign dbg_data_o = dbg_data_r;

endmodule
